spixfer: RTL and testbench
==========================

# spixfer

Parametrised SPI master transfer engine: shifts one WIDTH-bit word out on MOSI and, optionally, one word in from MISO. It owns the active-low chip select, with programmable setup/hold around the clock burst. SCL runs at a programmable divided rate in any of the four SPI modes. It replaces the fixed 24-bit, half-rate, mode-3, CS-less shifter and sits between command sequencers and off-chip DAC/ADC/driver devices.

## Interface
- WIDTH, 24: bits per transfer, MSB first; legal ≥2
- DIV, 1: SCL half-period in clk cycles; legal ≥1 (DIV=1 gives clk/2)
- MODE, 3: SPI mode {CPOL,CPHA}; default matches legacy (idle-high SCL, MOSI changes on falling edge)
- CS_SETUP, 1: clk cycles CS_n is low before the first SCL edge; legal ≥1
- CS_HOLD, 1: clk cycles CS_n stays low after the last SCL edge; legal ≥1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only while busy=0
- tx  in  WIDTH  word to send, captured on the accepted start
- busy  out  1  transfer in progress; start ignored while high
- done  out  1  one-cycle pulse marking the final cycle of a transfer
- rx  out  WIDTH  received word; updated in the done cycle, otherwise held
- MISO  in  1  serial data in
- MOSI  out  1  serial data out
- SCL  out  1  serial clock
- CS_n  out  1  chip select, active low

## Operation
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE & start=1: capture tx into the shift register, load the phase counter, go to SETUP; CS_n=0 from the next cycle.
- SETUP lasts CS_SETUP cycles with SCL=CPOL.
  - CPHA=0: MOSI=tx[WIDTH-1] throughout SETUP.
  - CPHA=1: MOSI holds 0 until the first edge.
- SHIFT lasts exactly 2·WIDTH·DIV cycles. SCL toggles every DIV cycles, giving WIDTH leading and WIDTH trailing edges.
  - CPHA=0: sample MISO on the leading edge; shift MOSI on the trailing edge (no shift after the last bit).
  - CPHA=1: shift MOSI on the leading edge (first leading edge presents bit WIDTH-1); sample on the trailing edge.
- Sampling: MISO is captured in the clk cycle that drives SCL to the sample level and shifted into rx_shift LSB-first-in, so bit WIDTH-1 ends MSB.
- HOLD lasts CS_HOLD cycles with SCL=CPOL and MOSI held. done=1 and rx←rx_shift in the last HOLD cycle.
- Next cycle: IDLE, CS_n=1, busy=0, MOSI=0.
- busy = (state≠IDLE), registered.
- Bit counter width $clog2(WIDTH+1); divide counter width $clog2(DIV) (min 1); both wrap only by reload, never by overflow.
- Reset values: CS_n=1, SCL=CPOL, MOSI=0, busy=0, done=0, rx=0, state=IDLE.
- Reset mid-transfer: all outputs take reset values next cycle; no done pulse; rx keeps 0.
- start while busy: ignored, not queued.
- start in the first cycle after done (busy=0): accepted; CS_n is high for exactly that one cycle.
- tx changes after acceptance have no effect.

## Timing
- start accepted at cycle 0 → busy=1, CS_n=0 in cycles 1…N, with N = CS_SETUP + 2·WIDTH·DIV + CS_HOLD.
- done and rx update in cycle N; busy=0, CS_n=1 in cycle N+1.
- Minimum start-to-start period: N+1 cycles.
- First SCL edge in cycle CS_SETUP+1; edges every DIV cycles thereafter.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SPIXFER_MISO_EN defined: MISO port, rx shift register and rx capture present as above.
- SPIXFER_MISO_EN undefined: MISO ignored (port kept, unused); rx tied to 0; no receive flops. done timing unchanged.

## Structure
- spixfer_pkg: state enum (IDLE, SETUP, SHIFT, HOLD), MODE bit-position constants (CPOL=1, CPHA=0), mode localparam helpers.
- One sub-module, spixfer_clkgen: DIV counter producing SCL plus single-cycle lead_edge/trail_edge strobes, enabled only in SHIFT and held at CPOL otherwise.

## Test plan
- WIDTH=24, DIV=1, MODE=3, MOSI looped to MISO; tx=0xA5C3F0, start at cycle 0 → 48 SCL edges, CS_n low cycles 1–50, done at 50, rx=0xA5C3F0, busy low at 51.
- WIDTH=16, DIV=3, MODE=0, MISO driven from a model returning 0x1234 → SCL low when idle, first rising edge at cycle 2, edge spacing 3, rx=0x1234, N=98.
- Each MODE 0–3 with tx=0x800001 and a device model checking the sample edge → no setup/hold violations against SCL; MOSI stable across each sample edge.
- start held high continuously with tx=0xFFFFFF then 0x000000 → back-to-back transfers with one CS_n-high cycle between; mid-transfer starts ignored.
- rst asserted in cycle 20 of a transfer → next cycle CS_n=1, SCL=CPOL, MOSI=0, busy=0; no done; rx=0.
- Build without SPIXFER_MISO_EN, MISO toggling randomly → rx stays 0; done still at cycle N.

Source files
------------

// File: rtl/spixfer_pkg.sv
// spixfer_pkg: shared constants and helpers for the spixfer SPI master.
// State encodings, SPI mode bit positions and small elaboration-time helpers.
package spixfer_pkg;

  // FSM state encodings (kept as plain constants for legacy tool flows)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  // Bit positions inside the 2-bit MODE value {CPOL,CPHA}
  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  // Idle level of SCL for a given mode
  function automatic logic mode_cpol(input int mode);
    logic [1:0] m;
    m = mode[1:0];
    return m[MODE_CPOL_BIT];
  endfunction

  // 1 when data is shifted on the leading edge and sampled on the trailing one
  function automatic logic mode_cpha(input int mode);
    logic [1:0] m;
    m = mode[1:0];
    return m[MODE_CPHA_BIT];
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold 0..v-1, never narrower than one bit
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/spixfer_clkgen.sv
// spixfer_clkgen: SCL divider for the spixfer SPI master.
// While en is high SCL toggles every DIV cycles starting in the first enabled
// cycle; lead_edge/trail_edge flag the cycle that drives SCL away from / back
// to its idle level. With en low SCL is forced to CPOL and the divider clears.
module spixfer_clkgen
  import spixfer_pkg::*;
#(
  parameter int   DIV  = 1,
  parameter logic CPOL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic scl,
  output logic lead_edge,
  output logic trail_edge
);

  localparam int DW = clog2_min1(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          scl_q, scl_d;
  logic          tick;

  assign tick       = en && (div_q == '0);
  assign lead_edge  = tick && (scl_q == CPOL);
  assign trail_edge = tick && (scl_q != CPOL);
  assign scl        = scl_q;

  // Divider and SCL next-state: toggle on each tick, park at CPOL when disabled
  always_comb begin
    div_d = '0;
    scl_d = CPOL;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      scl_d = tick ? ~scl_q : scl_q;
    end
  end

  // Divider and SCL registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      scl_q <= CPOL;
    end else begin
      div_q <= div_d;
      scl_q <= scl_d;
    end
  end

endmodule

// File: rtl/spixfer.sv
// spixfer: parametrised SPI master transfer engine (one WIDTH-bit word per
// transfer, MSB first, any SPI mode, programmable CS_n setup/hold).
// Optional receive path enabled by defining SPIXFER_MISO_EN; without it MISO
// is ignored and rx reads 0.
// All outputs come straight from flops; next-state values are computed from
// the upcoming state so that each output lines up with the state it reflects.
module spixfer
  import spixfer_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int DIV      = 1,
  parameter int MODE     = 3,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx,
  input  logic             MISO,
  output logic             MOSI,
  output logic             SCL,
  output logic             CS_n
);

  localparam logic CPOL   = mode_cpol(MODE);
  localparam logic CPHA   = mode_cpha(MODE);
  localparam int   SHIFT_CYCLES = 2 * WIDTH * DIV;
  localparam int   PH_W   = clog2_min1(max3(CS_SETUP, SHIFT_CYCLES, CS_HOLD));
  localparam int   BC_W   = $clog2(WIDTH + 1);

  localparam logic [PH_W-1:0] PH_SETUP = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0] PH_SHIFT = PH_W'(SHIFT_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_HOLD  = PH_W'(CS_HOLD - 1);
  localparam logic [BC_W-1:0] BC_LOAD  = BC_W'(WIDTH);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(1);

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BC_W-1:0]  bit_q, bit_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             done_q, done_d;
  logic             accept;
  logic             lead_edge, trail_edge;

  assign accept = (state_q == ST_IDLE) && start;

  // SCL generation runs for exactly the cycles that feed the SHIFT phase
  spixfer_clkgen #(
    .DIV  (DIV),
    .CPOL (CPOL)
  ) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .en         (state_d == ST_SHIFT),
    .scl        (SCL),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge)
  );

  // Phase sequencing: each phase loads its length-1 and counts down to zero
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          phase_d = PH_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_q == '0) begin
          state_d = ST_SHIFT;
          phase_d = PH_SHIFT;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (phase_q == '0) begin
          state_d = ST_HOLD;
          phase_d = PH_HOLD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q == '0) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Transmit shifter: CPHA=0 presents the MSB during setup and advances on
  // trailing edges (none after the last bit); CPHA=1 idles MOSI at 0 and
  // advances on leading edges. The bit counter tracks remaining trailing edges.
  always_comb begin
    sh_d   = sh_q;
    bit_d  = bit_q;
    mosi_d = mosi_q;
    if (accept) begin
      bit_d = BC_LOAD;
      if (CPHA) begin
        sh_d   = tx;
        mosi_d = 1'b0;
      end else begin
        sh_d   = tx << 1;
        mosi_d = tx[WIDTH-1];
      end
    end else begin
      if (CPHA && lead_edge) begin
        mosi_d = sh_q[WIDTH-1];
        sh_d   = sh_q << 1;
      end
      if (trail_edge) begin
        bit_d = bit_q - 1'b1;
        if (!CPHA && (bit_q != BC_LAST)) begin
          mosi_d = sh_q[WIDTH-1];
          sh_d   = sh_q << 1;
        end
      end
    end
    if (state_d == ST_IDLE) begin
      mosi_d = 1'b0;
    end
  end

  // Status outputs reflect the state of the cycle they are visible in
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    cs_n_d = (state_d == ST_IDLE);
    done_d = (state_d == ST_HOLD) && (phase_d == '0);
  end

  // Control and transmit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
    end
  end

  assign MOSI = mosi_q;
  assign busy = busy_q;
  assign CS_n = cs_n_q;
  assign done = done_q;

`ifdef SPIXFER_MISO_EN
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             sample;

  // MISO is taken in the cycle that drives SCL to the sampling level
  assign sample = CPHA ? trail_edge : lead_edge;

  // Receive shifter fills LSB-first-in; the word is published with done
  always_comb begin
    rx_shift_d = sample ? {rx_shift_q[WIDTH-2:0], MISO} : rx_shift_q;
    rx_d       = done_d ? rx_shift_d : rx_q;
  end

  // Receive registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift_q <= '0;
      rx_q       <= '0;
    end else begin
      rx_shift_q <= rx_shift_d;
      rx_q       <= rx_d;
    end
  end

  assign rx = rx_q;
`else
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx          = '0;
`endif

endmodule

// File: tb/tb_spixfer.sv
// tb_spixfer: directed self-checking bench for spixfer.
// Six instances share clk/rst: #0 24b/DIV1/mode3 with MOSI looped to MISO,
// #1 16b/DIV3/mode0, #2..#5 24b/DIV2/modes 0..3 with CS_SETUP=2, CS_HOLD=3.
// A per-instance slave model samples MOSI on the sample edge, drives MISO on
// the shift edge and records SCL edge timing.
module tb_spixfer;

`ifdef SPIXFER_MISO_EN
  localparam bit MISO_EN = 1'b1;
`else
  localparam bit MISO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s [6];
  logic [23:0] tx_s    [6];
  logic        busy_s  [6];
  logic        done_s  [6];
  logic [23:0] rx_s    [6];
  logic        miso_s  [6];
  logic        mosi_s  [6];
  logic        scl_s   [6];
  logic        cs_n_s  [6];

  logic        rand_miso = 1'b0;
  logic        rnd_bit   = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // slave model state
  logic [23:0] dev_word  [6];
  logic [23:0] dev_rcv   [6];
  logic        dev_miso  [6];
  int          dev_edges [6];
  int          dev_first [6];
  int          dev_last  [6];
  int          dev_spmin [6];
  int          dev_spmax [6];
  int          dev_viol  [6];
  int          dev_nsend [6];
  logic        prev_cs   [6];
  logic        prev_scl  [6];
  logic        prev_mosi [6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int w_of(input int i);
    return (i == 1) ? 16 : 24;
  endfunction
  function automatic logic [1:0] mode_of(input int i);
    return (i == 0) ? 2'd3 : (i == 1) ? 2'd0 : 2'(i - 2);
  endfunction
  function automatic logic cpol_of(input int i);
    logic [1:0] m;
    m = mode_of(i);
    return m[1];
  endfunction
  function automatic logic cpha_of(input int i);
    logic [1:0] m;
    m = mode_of(i);
    return m[0];
  endfunction
  function automatic logic [23:0] exp_rx(input logic [23:0] v);
    return MISO_EN ? v : 24'h0;
  endfunction

  for (genvar gi = 0; gi < 6; gi++) begin : g_dut
    localparam int W = (gi == 1) ? 16 : 24;
    localparam int D = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
    localparam int M = (gi == 0) ? 3 : (gi == 1) ? 0 : gi - 2;
    localparam int S = (gi >= 2) ? 2 : 1;
    localparam int H = (gi >= 2) ? 3 : 1;
    logic [W-1:0] rx_w;
    spixfer #(.WIDTH(W), .DIV(D), .MODE(M), .CS_SETUP(S), .CS_HOLD(H)) u_dut (
      .clk(clk), .rst(rst), .start(start_s[gi]), .tx(tx_s[gi][W-1:0]),
      .busy(busy_s[gi]), .done(done_s[gi]), .rx(rx_w), .MISO(miso_s[gi]),
      .MOSI(mosi_s[gi]), .SCL(scl_s[gi]), .CS_n(cs_n_s[gi])
    );
    assign rx_s[gi]   = 24'(rx_w);
    assign miso_s[gi] = rand_miso ? rnd_bit : ((gi == 0) ? mosi_s[gi] : dev_miso[gi]);
  end

  // slave models: observe outputs on the falling clk edge
  always @(negedge clk) begin
    int   w;
    logic slvl;
    for (int i = 0; i < 6; i++) begin
      w    = w_of(i);
      slvl = cpol_of(i) ^ ~cpha_of(i);
      if (!cs_n_s[i] && prev_cs[i]) begin
        dev_edges[i] = 0; dev_first[i] = -1; dev_spmin[i] = 100000; dev_spmax[i] = 0;
        dev_viol[i] = 0; dev_rcv[i] = 24'h0; dev_nsend[i] = 0;
        if (!cpha_of(i)) begin
          dev_miso[i]  = dev_word[i][w-1];
          dev_nsend[i] = 1;
        end
      end
      if (scl_s[i] != prev_scl[i]) begin
        if (cs_n_s[i]) dev_viol[i]++;
        dev_edges[i]++;
        if (dev_first[i] < 0) begin
          dev_first[i] = cyc;
        end else begin
          if (cyc - dev_last[i] < dev_spmin[i]) dev_spmin[i] = cyc - dev_last[i];
          if (cyc - dev_last[i] > dev_spmax[i]) dev_spmax[i] = cyc - dev_last[i];
        end
        dev_last[i] = cyc;
        if (scl_s[i] == slvl) begin
          if (mosi_s[i] != prev_mosi[i]) dev_viol[i]++;
          dev_rcv[i] = {dev_rcv[i][22:0], mosi_s[i]};
        end else if (dev_nsend[i] < w) begin
          dev_miso[i] = dev_word[i][w-1-dev_nsend[i]];
          dev_nsend[i]++;
        end
      end
      prev_cs[i]   = cs_n_s[i];
      prev_scl[i]  = scl_s[i];
      prev_mosi[i] = mosi_s[i];
    end
    rnd_bit = 1'($urandom);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Pulse start for one cycle on instance i; t0 is the cyc value of cycle 0
  task automatic launch(input int i, input logic [23:0] w, output int t0);
    tx_s[i]    = w;
    start_s[i] = 1'b1;
    t0         = cyc;
    step();
    start_s[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if ({cs_n_s[i], scl_s[i], mosi_s[i], busy_s[i], done_s[i]} !== {1'b1, cpol_of(i), 3'b000} ||
          rx_s[i] !== 24'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: cs_n=%b scl=%b mosi=%b busy=%b done=%b rx=%h, want 1 %b 0 0 0 0",
                 i, cs_n_s[i], scl_s[i], mosi_s[i], busy_s[i], done_s[i], rx_s[i], cpol_of(i));
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_loopback();
    int t0;
    launch(0, 24'hA5C3F0, t0);
    for (int k = 1; k <= 51; k++) begin
      n_checks++;
      if (busy_s[0] !== (k <= 50) || cs_n_s[0] !== (k > 50) || done_s[0] !== (k == 50)) begin
        n_fail++;
        $display("FAIL loopback_frame k=%0d: busy=%b cs_n=%b done=%b, want %b %b %b",
                 k, busy_s[0], cs_n_s[0], done_s[0], k <= 50, k > 50, k == 50);
      end
      if (k == 50) begin
        n_checks++;
        if (rx_s[0] !== exp_rx(24'hA5C3F0)) begin
          n_fail++;
          $display("FAIL loopback_rx: got %h want %h", rx_s[0], exp_rx(24'hA5C3F0));
        end
      end
      if (k == 51) begin
        n_checks++;
        if (mosi_s[0] !== 1'b0 || scl_s[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL loopback_idle: mosi=%b scl=%b want 0 1", mosi_s[0], scl_s[0]);
        end
      end
      if (k < 51) step();
    end
    n_checks++;
    if (dev_edges[0] !== 48 || dev_first[0] !== t0 + 2 || dev_spmin[0] !== 1 || dev_spmax[0] !== 1) begin
      n_fail++;
      $display("FAIL loopback_scl: edges=%0d first=%0d spacing=%0d..%0d want 48 %0d 1..1",
               dev_edges[0], dev_first[0] - t0, dev_spmin[0], dev_spmax[0], 2);
    end
    n_checks++;
    if (dev_viol[0] !== 0 || dev_rcv[0] !== 24'hA5C3F0) begin
      n_fail++;
      $display("FAIL loopback_mosi: viol=%0d slave_rcv=%h want 0 a5c3f0", dev_viol[0], dev_rcv[0]);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    launch(0, 24'h5A5A5A, t0);
    repeat (19) step();
    rst = 1'b1;
    step();
    n_checks++;
    if ({cs_n_s[0], scl_s[0], mosi_s[0], busy_s[0], done_s[0]} !== 5'b11000 || rx_s[0] !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid: cs_n=%b scl=%b mosi=%b busy=%b done=%b rx=%h want 1 1 0 0 0 0",
               cs_n_s[0], scl_s[0], mosi_s[0], busy_s[0], done_s[0], rx_s[0]);
    end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      n_checks++;
      if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || rx_s[0] !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_mid_after k=%0d: done=%b busy=%b rx=%h want 0 0 0", k, done_s[0], busy_s[0], rx_s[0]);
      end
    end
  endtask

  task automatic test_mode0_div3();
    int t0;
    dev_word[1] = 24'h001234;
    launch(1, 24'h00BEEF, t0);
    for (int k = 1; k <= 99; k++) begin
      n_checks++;
      if (busy_s[1] !== (k <= 98) || cs_n_s[1] !== (k > 98) || done_s[1] !== (k == 98)) begin
        n_fail++;
        $display("FAIL m0d3_frame k=%0d: busy=%b cs_n=%b done=%b, want %b %b %b",
                 k, busy_s[1], cs_n_s[1], done_s[1], k <= 98, k > 98, k == 98);
      end
      if (k == 98) begin
        n_checks++;
        if (rx_s[1] !== exp_rx(24'h001234)) begin
          n_fail++;
          $display("FAIL m0d3_rx: got %h want %h", rx_s[1], exp_rx(24'h001234));
        end
      end
      if (k < 99) step();
    end
    n_checks++;
    if (dev_edges[1] !== 32 || dev_first[1] !== t0 + 2 || dev_spmin[1] !== 3 || dev_spmax[1] !== 3 ||
        scl_s[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL m0d3_scl: edges=%0d first=%0d spacing=%0d..%0d scl=%b want 32 2 3..3 0",
               dev_edges[1], dev_first[1] - t0, dev_spmin[1], dev_spmax[1], scl_s[1]);
    end
    n_checks++;
    if (dev_viol[1] !== 0 || dev_rcv[1] !== 24'h00BEEF) begin
      n_fail++;
      $display("FAIL m0d3_mosi: viol=%0d slave_rcv=%h want 0 00beef", dev_viol[1], dev_rcv[1]);
    end
  endtask

  task automatic test_modes();
    int t0;
    for (int i = 2; i < 6; i++) begin
      dev_word[i] = 24'hC0FFEE;
      tx_s[i]     = 24'h800001;
      start_s[i]  = 1'b1;
    end
    t0 = cyc;
    step();
    for (int i = 2; i < 6; i++) start_s[i] = 1'b0;
    for (int k = 1; k <= 102; k++) begin
      for (int i = 2; i < 6; i++) begin
        n_checks++;
        if (busy_s[i] !== (k <= 101) || cs_n_s[i] !== (k > 101) || done_s[i] !== (k == 101)) begin
          n_fail++;
          $display("FAIL mode%0d_frame k=%0d: busy=%b cs_n=%b done=%b, want %b %b %b",
                   i - 2, k, busy_s[i], cs_n_s[i], done_s[i], k <= 101, k > 101, k == 101);
        end
        if (k == 101) begin
          n_checks++;
          if (rx_s[i] !== exp_rx(24'hC0FFEE)) begin
            n_fail++;
            $display("FAIL mode%0d_rx: got %h want %h", i - 2, rx_s[i], exp_rx(24'hC0FFEE));
          end
        end
      end
      if (k < 102) step();
    end
    for (int i = 2; i < 6; i++) begin
      n_checks++;
      if (dev_viol[i] !== 0 || dev_rcv[i] !== 24'h800001) begin
        n_fail++;
        $display("FAIL mode%0d_mosi: viol=%0d slave_rcv=%h want 0 800001", i - 2, dev_viol[i], dev_rcv[i]);
      end
      n_checks++;
      if (dev_edges[i] !== 48 || dev_first[i] !== t0 + 3 || dev_spmin[i] !== 2 || dev_spmax[i] !== 2 ||
          scl_s[i] !== cpol_of(i)) begin
        n_fail++;
        $display("FAIL mode%0d_scl: edges=%0d first=%0d spacing=%0d..%0d scl=%b want 48 3 2..2 %b",
                 i - 2, dev_edges[i], dev_first[i] - t0, dev_spmin[i], dev_spmax[i], scl_s[i], cpol_of(i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_busy;
    tx_s[0]    = 24'hFFFFFF;
    start_s[0] = 1'b1;
    step();
    tx_s[0] = 24'h000000;
    for (int k = 1; k <= 103; k++) begin
      exp_busy = (k <= 50) || (k >= 52 && k <= 101);
      n_checks++;
      if (busy_s[0] !== exp_busy || cs_n_s[0] !== !exp_busy || done_s[0] !== (k == 50 || k == 101)) begin
        n_fail++;
        $display("FAIL b2b_frame k=%0d: busy=%b cs_n=%b done=%b, want %b %b %b",
                 k, busy_s[0], cs_n_s[0], done_s[0], exp_busy, !exp_busy, k == 50 || k == 101);
      end
      if (k == 50) begin
        n_checks++;
        if (rx_s[0] !== exp_rx(24'hFFFFFF)) begin
          n_fail++;
          $display("FAIL b2b_rx1: got %h want %h", rx_s[0], exp_rx(24'hFFFFFF));
        end
      end
      if (k == 51) begin
        n_checks++;
        if (dev_rcv[0] !== 24'hFFFFFF) begin
          n_fail++;
          $display("FAIL b2b_slave1: got %h want ffffff", dev_rcv[0]);
        end
      end
      if (k == 101) begin
        n_checks++;
        if (rx_s[0] !== 24'h0 || dev_rcv[0] !== 24'h0) begin
          n_fail++;
          $display("FAIL b2b_word2: rx=%h slave_rcv=%h want 0 0", rx_s[0], dev_rcv[0]);
        end
      end
      if (k == 52) start_s[0] = 1'b0;
      if (k < 103) step();
    end
  endtask

  task automatic test_no_miso();
    int t0;
    rand_miso = 1'b1;
    launch(0, 24'h3C3C3C, t0);
    for (int k = 1; k <= 51; k++) begin
      n_checks++;
      if (busy_s[0] !== (k <= 50) || done_s[0] !== (k == 50)) begin
        n_fail++;
        $display("FAIL nomiso_frame k=%0d: busy=%b done=%b, want %b %b", k, busy_s[0], done_s[0], k <= 50, k == 50);
      end
`ifndef SPIXFER_MISO_EN
      if (k == 50) begin
        n_checks++;
        if (rx_s[0] !== 24'h0) begin
          n_fail++;
          $display("FAIL nomiso_rx: got %h want 000000", rx_s[0]);
        end
      end
`endif
      if (k < 51) step();
    end
    n_checks++;
    if (dev_rcv[0] !== 24'h3C3C3C) begin
      n_fail++;
      $display("FAIL nomiso_mosi: slave_rcv=%h want 3c3c3c", dev_rcv[0]);
    end
    rand_miso = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      start_s[i] = 1'b0; tx_s[i] = 24'h0; dev_word[i] = 24'h0; dev_rcv[i] = 24'h0;
      dev_miso[i] = 1'b0; dev_edges[i] = 0; dev_first[i] = -1; dev_last[i] = 0;
      dev_spmin[i] = 0; dev_spmax[i] = 0; dev_viol[i] = 0; dev_nsend[i] = 0;
      prev_cs[i] = 1'b1; prev_scl[i] = 1'b0; prev_mosi[i] = 1'b0;
    end
    test_reset();
    test_loopback();
    test_reset_mid();
    test_mode0_div3();
    test_modes();
    test_back_to_back();
    test_no_miso();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
